// File: rtl/dds_param_sequencer_if.sv
// Front-panel button / live-parameter bundle between debouncers, the
// sequencer and the DDS datapath.
`default_nettype none

interface dds_param_sequencer_if;
  logic        btn_mode;
  logic        btn_up;
  logic        btn_down;
  logic        phase_wrap;
  logic [12:0] phase_M;
  logic [10:0] signal_A;
  logic [1:0]  signal_shape;
  logic [1:0]  edit_sel;
  logic        pending;
  logic        param_upd;

  modport master (
    output btn_mode, btn_up, btn_down, phase_wrap,
    input  phase_M, signal_A, signal_shape, edit_sel, pending, param_upd
  );

  modport slave (
    input  btn_mode, btn_up, btn_down, phase_wrap,
    output phase_M, signal_A, signal_shape, edit_sel, pending, param_upd
  );
endinterface

`default_nettype wire

// File: rtl/dds_param_sequencer.sv
// DDS parameter editor: buttons edit shadow registers, which are committed to
// the live outputs on a phase wrap (or after a timeout) to avoid glitches.
`default_nettype none

module dds_param_sequencer #(
  parameter int unsigned M_INIT  = 500,
  parameter int unsigned A_INIT  = 1200,
  parameter int unsigned M_STEP  = 50,
  parameter int unsigned A_STEP  = 100,
  parameter int unsigned M_MIN   = 1,
  parameter int unsigned M_MAX   = 8191,
  parameter int unsigned A_MAX   = 2047,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic                   clk,
  input  logic                   rst,
  dds_param_sequencer_if.slave   bus
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [12:0] m_sh_q, m_sh_d, m_live_q, m_live_d;
  logic [10:0] a_sh_q, a_sh_d, a_live_q, a_live_d;
  logic [1:0]  s_sh_q, s_sh_d, s_live_q, s_live_d;
  logic [1:0]  sel_q, sel_d;
  logic        upd_q, upd_d;

  logic        edit_w;
  logic        commit_w;
  logic [13:0] m_up_w, m_dn_w;
  logic [11:0] a_up_w, a_dn_w;

  // Mode beats up/down; simultaneous up+down cancel.
  assign edit_w   = !bus.btn_mode && (bus.btn_up ^ bus.btn_down);
  assign commit_w = (state_q == ST_PENDING) &&
                    (bus.phase_wrap || (cnt_q == 12'(TIMEOUT - 1)));

  assign m_up_w = {1'b0, m_sh_q} + 14'(M_STEP);
  assign m_dn_w = {1'b0, m_sh_q} - 14'(M_STEP);
  assign a_up_w = {1'b0, a_sh_q} + 12'(A_STEP);
  assign a_dn_w = {1'b0, a_sh_q} - 12'(A_STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      m_sh_q   <= 13'(M_INIT);
      a_sh_q   <= 11'(A_INIT);
      s_sh_q   <= 2'd0;
      m_live_q <= 13'(M_INIT);
      a_live_q <= 11'(A_INIT);
      s_live_q <= 2'd0;
      sel_q    <= 2'd0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_sh_q   <= m_sh_d;
      a_sh_q   <= a_sh_d;
      s_sh_q   <= s_sh_d;
      m_live_q <= m_live_d;
      a_live_q <= a_live_d;
      s_live_q <= s_live_d;
      sel_q    <= sel_d;
      upd_q    <= upd_d;
    end
  end

  // Further edits inside PENDING keep the counter running so a busy user
  // cannot postpone the forced commit indefinitely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (edit_w) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (commit_w) begin
          cnt_d   = '0;
          state_d = edit_w ? ST_PENDING : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    sel_d    = sel_q;
    m_sh_d   = m_sh_q;
    a_sh_d   = a_sh_q;
    s_sh_d   = s_sh_q;
    m_live_d = m_live_q;
    a_live_d = a_live_q;
    s_live_d = s_live_q;
    upd_d    = commit_w;

    if (bus.btn_mode) begin
      sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
    end else if (edit_w) begin
      case (sel_q)
        2'd0: begin
          if (bus.btn_up)
            m_sh_d = (m_up_w > 14'(M_MAX)) ? 13'(M_MAX) : m_up_w[12:0];
          else
            m_sh_d = (m_dn_w[13] || m_dn_w < 14'(M_MIN)) ? 13'(M_MIN) : m_dn_w[12:0];
        end
        2'd1: begin
          if (bus.btn_up)
            a_sh_d = (a_up_w > 12'(A_MAX)) ? 11'(A_MAX) : a_up_w[10:0];
          else
            a_sh_d = a_dn_w[11] ? 11'd0 : a_dn_w[10:0];
        end
        default: begin
          if (bus.btn_up)
            s_sh_d = (s_sh_q == 2'd2) ? 2'd0 : s_sh_q + 2'd1;
          else
            s_sh_d = (s_sh_q == 2'd0) ? 2'd2 : s_sh_q - 2'd1;
        end
      endcase
    end

    if (commit_w) begin
      m_live_d = m_sh_q;
      a_live_d = a_sh_q;
      s_live_d = s_sh_q;
    end
  end

  assign bus.phase_M      = m_live_q;
  assign bus.signal_A     = a_live_q;
  assign bus.signal_shape = s_live_q;
  assign bus.edit_sel     = sel_q;
  assign bus.pending      = (state_q == ST_PENDING);
  assign bus.param_upd    = upd_q;

endmodule

`default_nettype wire
